button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
Collects single-cycle rising-edge pulses from the per-button edge detectors in the button_parse chain and latches each as a pending event. Shares a single event consumer (FSM, UART logger, LED controller) between all buttons. Pending events are granted round-robin and presented one at a time on a valid/ready handshake. Events that arrive while the same button is already pending are counted as drops.

Parameters:
WIDTH, 4, number of button event inputs; must be >= 2
IDX_W, $clog2(WIDTH), width of event_idx; derived, do not override
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  system clock, 125 MHz
rst  input  1  asynchronous, active-high reset
edge_pulse  input  WIDTH  one-cycle rising-edge pulses from edge_detector, one bit per button
event_valid  output  1  an event is presented on event_idx
event_ready  input  1  consumer accepts the event; transfer when event_valid && event_ready at a clk rising edge
event_idx  output  IDX_W  index of the button that generated the presented event
pending  output  WIDTH  latched, not-yet-granted events, registered
drop_count  output  CNT_W  number of events lost because the button was already pending; saturating
clear_drops  input  1  synchronous clear of drop_count

Behaviour:
- Reset (async, rst=1):
  - pending=0, event_valid=0, event_idx=0, drop_count=0.
  - Round-robin pointer ptr=0.
  - Reset mid-transfer discards the presented event and all pending events.
- Pending latch, per bit i, at each clk edge:
  - If edge_pulse[i]=1, pending[i] becomes 1.
  - Otherwise, if i is granted this edge, pending[i] becomes 0.
  - Otherwise pending[i] holds.
  - Grant and a new pulse on the same bit in the same cycle: pending[i] stays 1. This is not a drop.
- Drop: edge_pulse[i]=1 while pending[i]=1 and i is not granted this cycle.
  - drop_count increments by the number of such bits this cycle.
  - Saturates at 2^CNT_W-1.
- clear_drops=1: drop_count becomes the number of drops in that same cycle (0 if none). Clear applies before the add; no loss.
- Grant condition: a grant occurs at a clk edge when |pending and (event_valid=0 or event_ready=1).
  - Selected index: the first set bit of pending searching ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1.
  - On grant: event_idx <= sel, event_valid <= 1, pending[sel] cleared as above, ptr <= (sel+1) mod WIDTH.
- No grant with event_valid && event_ready: event_valid <= 0; event_idx holds its last value.
- No grant with event_valid && !event_ready: event_valid and event_idx hold, stable until accepted. The consumer must not see event_idx change while event_valid=1.
- Throughput: back-to-back transfers, one per cycle, when event_ready is held high and pending is non-empty.
- Latency: pulse high in the cycle before edge E0 -> pending[i]=1 after E0 -> event_valid=1, event_idx=i after E1 (no backpressure). Two edges, no combinational path from edge_pulse to outputs.
- Only the arbiter consumes pending; edge_pulse never bypasses to event_idx.
- All outputs are registered.

Test Plan:
- WIDTH=4. Reset, then single pulse on bit 2 with event_ready=1 -> pending=4'b0100 one cycle later; next cycle event_valid=1, event_idx=2, pending=0; following cycle event_valid=0.
- Pulses on bits 0,1,3 in the same cycle with event_ready=1 -> event_idx sequence 0,1,3 on three consecutive cycles with event_valid=1 continuously, then valid drops.
- Round-robin fairness: grant bit 1, then pulse bits 0 and 2 simultaneously -> 2 granted before 0 (ptr=2).
- Backpressure: event_ready=0 for 5 cycles after event_idx=3 is presented, while pulsing bit 0 -> event_idx stays 3, event_valid stays 1, pending[0]=1. Raise ready -> 3 is accepted, then idx 0.
- Drops: pulse bit 1 three times while event_ready=0 and bit 1 is pending -> drop_count=2. Assert clear_drops with a simultaneous drop -> drop_count=1. Force 300 drops (CNT_W=8) -> drop_count=255.
- Assert rst mid-transfer (event_valid=1, pending=4'b1010) -> immediately event_valid=0, pending=0, drop_count=0. After release, a pulse on bit 3 is granted first (ptr=0 search reaches 3).

Source files
------------

// File: rtl/button_event_if.sv
// Valid/ready channel carrying the index of one granted button event.
// The arbiter drives the master side; the event consumer uses the slave side.
interface button_event_if #(
    parameter int IDX_W = 2
) ();
    logic             event_valid;
    logic             event_ready;
    logic [IDX_W-1:0] event_idx;

    modport master (
        output event_valid,
        output event_idx,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_idx,
        output event_ready
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Latches per-button edge pulses as pending events and hands them one at a time,
// round-robin, to a single consumer over a valid/ready channel; counts lost events.
module button_event_arbiter #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] edge_pulse,
    button_event_if.master   ev,
    output logic [WIDTH-1:0] pending,
    output logic [CNT_W-1:0] drop_count,
    input  logic             clear_drops
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] sel;
    logic             grant;
    logic [WIDTH-1:0] upper_mask;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] grant_vec;
    logic [WIDTH-1:0] drop_vec;
    logic [WIDTH-1:0] pending_nxt;
    logic [CNT_W-1:0] drop_nxt;

    function automatic logic [IDX_W-1:0] first_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W + 1)'(v[i]);
        end
        return c;
    endfunction

    // Saturating add: any carry out of the counter width pins the result at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [IDX_W:0]   n);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(n);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            upper_mask[i] = (IDX_W'(i) >= ptr);
        end
        // Search ptr..WIDTH-1 first, then wrap to the lowest pending bit.
        upper = pending & upper_mask;
        sel   = (|upper) ? first_set(upper) : first_set(pending);
        grant = (|pending) && (!ev.event_valid || ev.event_ready);
        for (int i = 0; i < WIDTH; i++) begin
            grant_vec[i] = grant && (sel == IDX_W'(i));
        end
        // A pulse on a bit granted this same edge re-arms it instead of dropping.
        drop_vec    = edge_pulse & pending & ~grant_vec;
        pending_nxt = edge_pulse | (pending & ~grant_vec);
        drop_nxt    = sat_add(clear_drops ? '0 : drop_count, popcount(drop_vec));
        ptr_nxt     = (sel == IDX_W'(WIDTH - 1)) ? '0 : sel + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending        <= '0;
            drop_count     <= '0;
            ptr            <= '0;
            ev.event_valid <= 1'b0;
            ev.event_idx   <= '0;
        end else begin
            pending    <= pending_nxt;
            drop_count <= drop_nxt;
            if (grant) begin
                ptr            <= ptr_nxt;
                ev.event_valid <= 1'b1;
                ev.event_idx   <= sel;
            end else if (ev.event_valid && ev.event_ready) begin
                ev.event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: expected grants are queued as stimulus
// is issued and a monitor pops and compares on every valid/ready transfer.
module tb_button_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] edge_pulse;
    logic [3:0] pending;
    logic [7:0] drop_count;
    logic       clear_drops;

    int vectors;
    int miscompares;
    logic [1:0] exp_q[$];

    button_event_if #(.IDX_W(2)) bus ();

    button_event_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .edge_pulse  (edge_pulse),
        .ev          (bus.master),
        .pending     (pending),
        .drop_count  (drop_count),
        .clear_drops (clear_drops)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        edge_pulse = m;
        tick();
        edge_pulse = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Transfer monitor: handshake seen mid-cycle completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.event_valid && bus.event_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", 32'(bus.event_idx), 32'hFFFF_FFFF);
            end else begin
                chk("transfer_idx", 32'(bus.event_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        edge_pulse      = 4'b0000;
        clear_drops     = 1'b0;
        bus.event_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.event_valid), 32'd0);
        chk("rst_idx", 32'(bus.event_idx), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        rst = 1'b0;

        // Single pulse on bit 2: two-edge latency, then valid falls.
        exp_q.push_back(2'd2);
        pulse(4'b0100);
        chk("t1_pending", 32'(pending), 32'h4);
        chk("t1_valid_early", 32'(bus.event_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(bus.event_valid), 32'd1);
        chk("t1_idx", 32'(bus.event_idx), 32'd2);
        chk("t1_pending_clr", 32'(pending), 32'd0);
        tick();
        chk("t1_valid_off", 32'(bus.event_valid), 32'd0);

        // Three simultaneous pulses from ptr=0: back-to-back 0,1,3.
        do_reset();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        pulse(4'b1011);
        chk("t2_pending", 32'(pending), 32'hB);
        tick();
        chk("t2_idx0", 32'(bus.event_idx), 32'd0);
        chk("t2_valid0", 32'(bus.event_valid), 32'd1);
        tick();
        chk("t2_idx1", 32'(bus.event_idx), 32'd1);
        chk("t2_valid1", 32'(bus.event_valid), 32'd1);
        tick();
        chk("t2_idx3", 32'(bus.event_idx), 32'd3);
        chk("t2_valid3", 32'(bus.event_valid), 32'd1);
        tick();
        chk("t2_valid_off", 32'(bus.event_valid), 32'd0);

        // Fairness: after granting 1 (ptr=2), bit 2 wins over bit 0.
        exp_q.push_back(2'd1);
        pulse(4'b0010);
        tick();
        chk("t3_idx1", 32'(bus.event_idx), 32'd1);
        tick();
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        pulse(4'b0101);
        tick();
        chk("t3_idx2", 32'(bus.event_idx), 32'd2);
        tick();
        chk("t3_idx0", 32'(bus.event_idx), 32'd0);
        tick();
        chk("t3_valid_off", 32'(bus.event_valid), 32'd0);

        // Backpressure: idx 3 held stable while bit 0 waits pending.
        bus.event_ready = 1'b0;
        pulse(4'b1000);
        tick();
        chk("t4_valid", 32'(bus.event_valid), 32'd1);
        chk("t4_idx", 32'(bus.event_idx), 32'd3);
        pulse(4'b0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold_valid", 32'(bus.event_valid), 32'd1);
            chk("t4_hold_idx", 32'(bus.event_idx), 32'd3);
            chk("t4_hold_pend0", 32'(pending[0]), 32'd1);
        end
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        bus.event_ready = 1'b1;
        tick();
        chk("t4_next_idx", 32'(bus.event_idx), 32'd0);
        chk("t4_next_valid", 32'(bus.event_valid), 32'd1);
        chk("t4_pending_clr", 32'(pending), 32'd0);
        tick();
        chk("t4_valid_off", 32'(bus.event_valid), 32'd0);

        // Drops: consumer stalled on idx 3 while bit 1 is pulsed repeatedly.
        bus.event_ready = 1'b0;
        pulse(4'b1000);
        tick();
        chk("t5_stall_idx", 32'(bus.event_idx), 32'd3);
        pulse(4'b0010);
        chk("t5_pend1", 32'(pending), 32'h2);
        chk("t5_drops0", 32'(drop_count), 32'd0);
        pulse(4'b0010);
        pulse(4'b0010);
        chk("t5_drops2", 32'(drop_count), 32'd2);
        edge_pulse  = 4'b0010;
        clear_drops = 1'b1;
        tick();
        clear_drops = 1'b0;
        chk("t5_clear_with_drop", 32'(drop_count), 32'd1);
        repeat (253) tick();
        chk("t5_drops254", 32'(drop_count), 32'd254);
        repeat (47) tick();
        edge_pulse = 4'b0000;
        chk("t5_drops_sat", 32'(drop_count), 32'd255);
        clear_drops = 1'b1;
        tick();
        clear_drops = 1'b0;
        chk("t5_clear_plain", 32'(drop_count), 32'd0);

        // Asynchronous reset with a stalled transfer and pending=1010.
        pulse(4'b1000);
        chk("t6_pending", 32'(pending), 32'hA);
        chk("t6_valid", 32'(bus.event_valid), 32'd1);
        pulse(4'b0010);
        chk("t6_drops_pre", 32'(drop_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.event_valid), 32'd0);
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_drops", 32'(drop_count), 32'd0);
        chk("t6_rst_idx", 32'(bus.event_idx), 32'd0);
        tick();
        rst = 1'b0;
        bus.event_ready = 1'b1;
        exp_q.push_back(2'd3);
        pulse(4'b1000);
        tick();
        chk("t6_post_valid", 32'(bus.event_valid), 32'd1);
        chk("t6_post_idx", 32'(bus.event_idx), 32'd3);
        tick();
        chk("t6_post_valid_off", 32'(bus.event_valid), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
